// File: rtl/gshare_pht_pkg.sv
// Shared branch-prediction constants: history width, 2-bit counter encodings,
// sweep init value and the conditional-branch opcode.
package gshare_pht_pkg;

  localparam int         BP_HIST_W   = 10;
  localparam logic [6:0] BP_OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] BP_INIT_CTR = CTR_WNT;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/gshare_pht_sat_ctr2.sv
// Combinational 2-bit saturating counter step: taken counts up, not-taken down.
module sat_ctr2
  import gshare_pht_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: PC^history indexed 2-bit counters, registered
// prediction, resolved-branch training and a saturating mispredict counter.
module gshare_pht
  import gshare_pht_pkg::*;
#(
  parameter int         HIST_W   = BP_HIST_W,
  parameter logic [1:0] INIT_CTR = BP_INIT_CTR,
  parameter int         STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HIST_W-1:0] ghr_addr,
  input  logic              lk_valid,
  input  logic [31:0]       lk_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_index,
  input  logic              upd_valid,
  input  logic [HIST_W-1:0] upd_index,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic              ready,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 1 << HIST_W;

  state_e            state, state_n;
  logic [HIST_W-1:0] ptr;
  logic [1:0]        pht [DEPTH];

  logic              run, lk_acc, upd_en;
  logic [HIST_W-1:0] lk_idx;
  logic [1:0]        upd_cur, upd_nxt, lk_ctr;
  logic              unused_pc;

  assign run       = (state == S_RUN);
  assign ready     = run;
  assign lk_acc    = lk_valid & run;
  assign upd_en    = upd_valid & run;
  assign lk_idx    = lk_pc[HIST_W+1:2] ^ ghr_addr;
  assign unused_pc = ^{lk_pc[31:HIST_W+2], lk_pc[1:0]};

  assign upd_cur = pht[upd_index];

  sat_ctr2 u_sat (
    .ctr   (upd_cur),
    .taken (upd_taken),
    .nxt   (upd_nxt)
  );

  // Write-first: a same-cycle update to the looked-up entry is visible to the lookup.
  always_comb begin
    lk_ctr = pht[lk_idx];
    if (upd_en && (upd_index == lk_idx)) lk_ctr = upd_nxt;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_INIT:  if (&ptr) state_n = S_RUN;
      S_RUN:   state_n = S_RUN;
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      if (state == S_INIT) ptr <= ptr + 1'b1;
    end
  end

  // Table storage is not reset; the sweep owns every entry while in INIT.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run)        pht[ptr]       <= INIT_CTR;
      else if (upd_en) pht[upd_index] <= upd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_index  <= '0;
      mispred_cnt <= '0;
    end else begin
      pred_valid <= lk_acc;
      if (lk_acc) begin
        pred_taken <= lk_ctr[1];
        pred_index <= lk_idx;
      end
      if (upd_en && upd_mispredict && !(&mispred_cnt))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
Pattern history table consuming the 10-bit global history index produced by the branch history register. It XORs the history with PC bits to form a gshare index and holds 2^HIST_W 2-bit saturating counters. It returns a registered taken/not-taken prediction to fetch. Resolved-branch updates from execute train the counters.

Parameters:
HIST_W, 10, history/index width; must match the history register width
INIT_CTR, 2'b01, counter value written by the init sweep (weakly not-taken)
STAT_W, 32, width of the misprediction statistics counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
ghr_addr  in  HIST_W  global history from the history register
lk_valid  in  1  lookup request (fetch of a conditional branch, opcode 1100011)
lk_pc  in  32  PC of the looked-up instruction
pred_valid  out  1  prediction valid, one cycle after an accepted lookup
pred_taken  out  1  predicted direction (counter MSB)
pred_index  out  HIST_W  index used; carried down the pipe for update
upd_valid  in  1  branch resolved
upd_index  in  HIST_W  index returned with the branch (pred_index at lookup time)
upd_taken  in  1  actual outcome (PCsel)
upd_mispredict  in  1  resolved direction differed from prediction
ready  out  1  init sweep complete; table accepting traffic
mispred_cnt  out  STAT_W  saturating count of mispredicted updates

Behaviour:
- Index = lk_pc[HIST_W+1:2] XOR ghr_addr, sampled when lk_valid is high.
- FSM states: INIT, RUN.
  - Reset → INIT with sweep pointer = 0.
  - INIT: write INIT_CTR to entry[ptr] and increment ptr by one each cycle.
  - INIT → RUN on the cycle ptr = 2^HIST_W-1 is written, i.e. 2^HIST_W cycles after reset release.
  - RUN persists until reset.
- Reset values: pred_valid=0, pred_taken=0, pred_index=0, ready=0, mispred_cnt=0, ptr=0. Counter array contents are undefined until the sweep writes them.
- ready = 1 only in RUN, registered; it asserts the cycle after the last sweep write.
- During INIT, lookups and updates are dropped: pred_valid stays 0, no counter change, mispred_cnt unchanged.
- Lookup latency is 1 cycle. pred_valid, pred_taken and pred_index register on the edge after lk_valid. pred_valid is low in any cycle following no lookup. Outputs hold their last values when pred_valid=0, except pred_valid itself.
- Update, single cycle, in RUN with upd_valid:
  - upd_taken=1: counter increments, saturating at 2'b11.
  - upd_taken=0: counter decrements, saturating at 2'b00.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = MSB.
- Same-cycle lookup and update to the same index: the prediction uses the post-update counter (write-first bypass). Different indices proceed independently.
- mispred_cnt increments by 1 on each RUN-state update with upd_mispredict=1 and saturates at all-ones; it does not wrap.
- Reset asserted mid-operation (INIT or RUN): the next edge returns to INIT with ptr=0, ready=0 and outputs cleared. The full sweep reruns and all training is lost.
- The history register is not modified by this block.

Decomposition:
- Shared branch-prediction package:
  - HIST_W
  - the 2-bit counter encodings (SNT/WNT/WT/ST)
  - INIT_CTR
  - the branch opcode constant 7'b1100011
- One sub-module, sat_ctr2: combinational 2-bit saturating next-state function (ctr, taken → next).
- The array and FSM live in gshare_pht.

Test Plan:
- Reset sequence: hold rst_n=0 for 3 cycles, then release → ready=0 for exactly 1024 cycles, then ready=1. A lookup at any pc/ghr_addr then gives pred_taken=0 with pred_valid pulsing one cycle later.
- Index hashing and training: lk_pc=0x0000_0010, ghr_addr=0x3FF → pred_index=0x3FB. Two updates at 0x3FB with taken=1, then a lookup → pred_taken=1. Third and fourth taken updates leave the counter at 11. One not-taken update → still taken. A second not-taken update → pred_taken=0.
- Saturation low: three not-taken updates on fresh index 0x005 → counter 00. A lookup gives 0. One taken update → still 0 (01).
- Bypass: counter at 0x3FB = 01; same cycle lk (index 0x3FB) and upd taken to 0x3FB → pred_taken=1 next cycle. The same test with a different upd_index → pred_taken=0.
- Init drop and reset mid-run: train index 0x3FB to 11, pulse rst_n=0 for 1 cycle, then issue upd_valid and lk_valid during the sweep → pred_valid=0 throughout. After ready, a lookup at 0x3FB → pred_taken=0 and mispred_cnt=0.
- Statistics: 5 updates with upd_mispredict=1 and 3 with 0 → mispred_cnt=5. Force the counter to all-ones minus 1 and apply 2 mispredicts → it holds at all-ones.
